tlb_unit: RTL and testbench

//  Fully associative TLB sitting directly upstream of the data cache: translates the CPU's virtual byte

---
 rtl/tlb_unit_pkg.sv | 22 ++
 rtl/tlb_unit_lru.sv | 35 +++
 rtl/tlb_unit.sv | 208 ++++++++++++++++++++
 tb/tb_tlb_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_unit_pkg.sv
// Shared TLB definitions: default geometry, walk FSM encoding, saturating counter helper.
// Latency/backpressure: n/a (types and constants only).
package tlb_unit_pkg;

  localparam int VA_W_DEF    = 14;
  localparam int PA_W_DEF    = 10;
  localparam int OFF_W_DEF   = 8;
  localparam int ENTRIES_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_READY,
    S_FAULT
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tlb_unit_lru.sv
// True-LRU age matrix: touched entry becomes age 0, younger entries age by one; lru_idx is the oldest.
// Latency: touch takes effect next cycle; lru_idx is combinational from the ages. No backpressure.
module tlb_unit_lru #(
  parameter int  ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] lru_idx
);

  logic [IDX_W-1:0] age [ENTRIES];

  // ages always form a permutation of 0..ENTRIES-1, so only entries younger than the touched one move
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) age[i] <= IDX_W'(ENTRIES - 1 - i);
    end else if (touch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx)        age[i] <= '0;
        else if (age[i] < age[touch_idx])  age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (age[i] == IDX_W'(ENTRIES - 1)) lru_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Fully associative TLB with page-table walk, victim write-back and true LRU; TLB_STATS_EN adds hit/miss/fault counters.
// Latency: hit 1 cycle to addr_prepared; miss waits on pt_done (WB then FILL). cpu_req is held by the CPU until answered.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter int VA_W    = VA_W_DEF,
  parameter int PA_W    = PA_W_DEF,
  parameter int OFF_W   = OFF_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  write_in,
  input  logic [VA_W-1:0]       virt_addr,
  output logic                  addr_prepared,
  output logic [PA_W-1:0]       phys_addr,
  output logic                  page_fault,
  output logic                  pt_req,
  output logic                  pt_we,
  output logic [VA_W-OFF_W-1:0] pt_vpn,
  output logic [PA_W-OFF_W+2:0] pt_wdata,
  input  logic [PA_W-OFF_W+2:0] pt_rdata,
  input  logic                  pt_done
`ifdef TLB_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count,
  output logic [15:0]           fault_count
`endif
);

  localparam int VPN_W = VA_W - OFF_W;
  localparam int PPN_W = PA_W - OFF_W;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic             refd;
    logic [PPN_W-1:0] ppn;
  } pte_t;

  pte_t             ent     [ENTRIES];
  logic [VPN_W-1:0] ent_vpn [ENTRIES];

  state_t           state, state_nxt;
  logic [VPN_W-1:0] req_vpn;
  logic [OFF_W-1:0] req_off;
  logic             req_wr;
  logic [IDX_W-1:0] victim_idx;

  logic [VPN_W-1:0] cur_vpn;
  logic             hit, free_vld;
  logic [IDX_W-1:0] hit_idx, free_idx, lru_idx, victim_sel;
  logic             touch;
  logic [IDX_W-1:0] touch_idx;
  pte_t             rdata;
  logic             unused_pt;

  assign cur_vpn   = virt_addr[VA_W-1:OFF_W];
  assign rdata     = pt_rdata;
  assign unused_pt = &{1'b0, rdata.dirty, rdata.refd};

  // descending scan so the lowest free index wins
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].valid && ent_vpn[i] == cur_vpn) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!ent[i].valid) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign victim_sel = free_vld ? free_idx : lru_idx;

  tlb_unit_lru #(.ENTRIES(ENTRIES)) u_lru (
    .clock     (clock),
    .reset     (reset),
    .touch     (touch),
    .touch_idx (touch_idx),
    .lru_idx   (lru_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    touch         = 1'b0;
    touch_idx     = hit_idx;
    addr_prepared = 1'b0;
    page_fault    = 1'b0;
    pt_req        = 1'b0;
    pt_we         = 1'b0;
    pt_vpn        = '0;
    pt_wdata      = '0;
    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            state_nxt = S_READY;
            touch     = 1'b1;
          end else if (ent[victim_sel].valid && (ent[victim_sel].dirty || ent[victim_sel].refd)) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end
      S_WB: begin
        pt_req   = 1'b1;
        pt_we    = 1'b1;
        pt_vpn   = ent_vpn[victim_idx];
        pt_wdata = {1'b1, ent[victim_idx].dirty, ent[victim_idx].refd, ent[victim_idx].ppn};
        if (pt_done) state_nxt = S_FILL;
      end
      S_FILL: begin
        pt_req = 1'b1;
        pt_vpn = req_vpn;
        if (pt_done) begin
          if (rdata.valid) begin
            touch     = 1'b1;
            touch_idx = victim_idx;
            state_nxt = cpu_req ? S_READY : S_IDLE;
          end else begin
            state_nxt = cpu_req ? S_FAULT : S_IDLE;
          end
        end
      end
      S_READY: begin
        addr_prepared = 1'b1;
        if (!cpu_req) state_nxt = S_IDLE;
      end
      S_FAULT: begin
        page_fault = 1'b1;
        if (!cpu_req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // request fields are latched at IDLE exit so a walk completes even if the CPU drops cpu_req
  always_ff @(posedge clock) begin
    if (reset) begin
      req_vpn    <= '0;
      req_off    <= '0;
      req_wr     <= 1'b0;
      victim_idx <= '0;
      phys_addr  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent[i]     <= '0;
        ent_vpn[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && cpu_req) begin
        req_vpn    <= cur_vpn;
        req_off    <= virt_addr[OFF_W-1:0];
        req_wr     <= write_in;
        victim_idx <= victim_sel;
        if (hit) begin
          phys_addr          <= {ent[hit_idx].ppn, virt_addr[OFF_W-1:0]};
          ent[hit_idx].refd  <= 1'b1;
          if (write_in) ent[hit_idx].dirty <= 1'b1;
        end
      end
      if (state == S_FILL && pt_done) begin
        if (rdata.valid) begin
          ent[victim_idx].valid <= 1'b1;
          ent[victim_idx].dirty <= req_wr;
          ent[victim_idx].refd  <= 1'b1;
          ent[victim_idx].ppn   <= rdata.ppn;
          ent_vpn[victim_idx]   <= req_vpn;
          phys_addr             <= {rdata.ppn, req_off};
        end else begin
          ent[victim_idx].valid <= 1'b0;
        end
      end
    end
  end

`ifdef TLB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count   <= '0;
      miss_count  <= '0;
      fault_count <= '0;
    end else begin
      if (state == S_IDLE && cpu_req) begin
        if (hit) hit_count  <= sat_inc16(hit_count);
        else     miss_count <= sat_inc16(miss_count);
      end
      if (state == S_FILL && pt_done && !rdata.valid) fault_count <= sat_inc16(fault_count);
    end
  end
`endif

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: page-table responder model, scoreboard of expected translations/faults.
// Build with TLB_STATS_EN defined to also check the counters.
module tb_tlb_unit;

  logic        clock = 1'b0;
  logic        reset, cpu_req, write_in;
  logic [13:0] virt_addr;
  logic        addr_prepared, page_fault, pt_req, pt_we, pt_done;
  logic [9:0]  phys_addr;
  logic [5:0]  pt_vpn;
  logic [4:0]  pt_wdata, pt_rdata;
`ifdef TLB_STATS_EN
  logic [15:0] hit_count, miss_count, fault_count;
`endif

  always #5 clock = ~clock;

  tlb_unit dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .write_in      (write_in),
    .virt_addr     (virt_addr),
    .addr_prepared (addr_prepared),
    .phys_addr     (phys_addr),
    .page_fault    (page_fault),
    .pt_req        (pt_req),
    .pt_we         (pt_we),
    .pt_vpn        (pt_vpn),
    .pt_wdata      (pt_wdata),
    .pt_rdata      (pt_rdata),
    .pt_done       (pt_done)
`ifdef TLB_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .fault_count   (fault_count)
`endif
  );

  typedef struct packed {
    logic       we;
    logic [5:0] vpn;
    logic [4:0] wdata;
  } txn_t;

  typedef struct packed {
    logic       fault;
    logic [9:0] pa;
  } exp_t;

  txn_t       txn_q [$];
  exp_t       exp_q [$];
  logic [4:0] pt_mem [64];
  bit         pt_hold = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  // page-table model: answers two cycles into a request, forgets an abandoned one
  initial begin
    int cnt;
    cnt      = 0;
    pt_done  = 1'b0;
    pt_rdata = '0;
    forever begin
      @(negedge clock);
      if (pt_done) begin
        pt_done = 1'b0;
        cnt     = 0;
      end else if (pt_req && !pt_hold) begin
        cnt++;
        if (cnt >= 2) begin
          pt_done = 1'b1;
          txn_q.push_back('{we: pt_we, vpn: pt_vpn, wdata: pt_wdata});
          if (pt_we) pt_mem[pt_vpn] = pt_wdata;
          else       pt_rdata = pt_mem[pt_vpn];
          cnt = 0;
        end
      end else if (!pt_req) begin
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    cpu_req   = 1'b0;
    write_in  = 1'b0;
    virt_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " addr_prepared"}, 32'(addr_prepared), 32'd0);
    chk({tag, " page_fault"},    32'(page_fault),    32'd0);
    chk({tag, " pt_req"},        32'(pt_req),        32'd0);
    chk({tag, " pt_we"},         32'(pt_we),         32'd0);
    chk({tag, " pt_vpn"},        32'(pt_vpn),        32'd0);
    chk({tag, " pt_wdata"},      32'(pt_wdata),      32'd0);
    chk({tag, " phys_addr"},     32'(phys_addr),     32'd0);
  endtask

  // lat < 0: latency not checked; hold: extra cycles cpu_req stays high after the answer
  task automatic translate(input string tag, input logic [13:0] va, input logic wr,
                           input logic exp_fault, input logic [9:0] exp_pa,
                           input int lat_exp, input int hold);
    exp_t e;
    int   lat;
    exp_q.push_back('{fault: exp_fault, pa: exp_pa});
    @(negedge clock);
    cpu_req   = 1'b1;
    virt_addr = va;
    write_in  = wr;
    lat       = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!(addr_prepared || page_fault) && lat < 200);
    chk({tag, " answered"}, 32'(lat < 200), 32'd1);
    e = exp_q.pop_front();
    chk({tag, " page_fault"},    32'(page_fault),    32'(e.fault));
    chk({tag, " addr_prepared"}, 32'(addr_prepared), 32'(!e.fault));
    if (!e.fault) chk({tag, " phys_addr"}, 32'(phys_addr), 32'(e.pa));
    if (lat_exp >= 0) chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, " held page_fault"},    32'(page_fault),    32'(e.fault));
      chk({tag, " held addr_prepared"}, 32'(addr_prepared), 32'(!e.fault));
    end
    cpu_req  = 1'b0;
    write_in = 1'b0;
    @(negedge clock);
    chk({tag, " release"}, 32'(addr_prepared | page_fault), 32'd0);
  endtask

  initial begin
    int  n0;
    bit  seen;
    for (int i = 0; i < 64; i++) pt_mem[i] = 5'b00000;
    pt_mem[1] = 5'b10010;
    pt_mem[2] = 5'b10001;
    pt_mem[3] = 5'b10011;
    pt_mem[4] = 5'b10000;
    pt_mem[5] = 5'b10001;
    pt_mem[6] = 5'b10001;
    pt_mem[7] = 5'b10011;
    reset = 1'b1; cpu_req = 1'b0; write_in = 1'b0; virt_addr = '0;

    // reset state
    do_reset();
    chk_idle_outputs("reset");
`ifdef TLB_STATS_EN
    chk("reset hit_count",   32'(hit_count),   32'd0);
    chk("reset miss_count",  32'(miss_count),  32'd0);
    chk("reset fault_count", 32'(fault_count), 32'd0);
`endif

    // first read walks the table, repeat hits in one cycle
    translate("t1 miss", 14'h0123, 1'b0, 1'b0, 10'h223, 3, 0);
    chk("t1 txn count", 32'(txn_q.size()), 32'd1);
    chk("t1 txn we",    32'(txn_q[0].we),  32'd0);
    chk("t1 txn vpn",   32'(txn_q[0].vpn), 32'h01);
    translate("t1 hit", 14'h0123, 1'b0, 1'b0, 10'h223, 1, 0);
    chk("t1 hit no walk", 32'(txn_q.size()), 32'd1);

    // invalid page-table entry faults and holds; retry walks again
    translate("t3 fault", 14'h3F00, 1'b0, 1'b1, 10'h000, 3, 2);
    chk("t3 txn vpn", 32'(txn_q[$].vpn), 32'h3F);
`ifdef TLB_STATS_EN
    chk("stats hit_count",   32'(hit_count),   32'd1);
    chk("stats miss_count",  32'(miss_count),  32'd2);
    chk("stats fault_count", 32'(fault_count), 32'd1);
`endif
    n0 = txn_q.size();
    translate("t3 retry", 14'h3F00, 1'b0, 1'b1, 10'h000, 3, 0);
    chk("t3 retry walks", 32'(txn_q.size()), 32'(n0 + 1));
    chk("t3 retry vpn",   32'(txn_q[$].vpn), 32'h3F);

    // store hit, then fill the rest and evict the dirty vpn 1
    translate("t2 store", 14'h0150, 1'b1, 1'b0, 10'h250, 1, 0);
    n0 = txn_q.size();
    translate("t2 vpn2", 14'h0210, 1'b0, 1'b0, 10'h110, 3, 0);
    translate("t2 vpn3", 14'h0333, 1'b0, 1'b0, 10'h333, 3, 0);
    translate("t2 vpn4", 14'h04AA, 1'b0, 1'b0, 10'h0AA, 3, 0);
    translate("t2 vpn5", 14'h0501, 1'b0, 1'b0, 10'h101, 6, 0);
    chk("t2 txn count", 32'(txn_q.size()),       32'(n0 + 5));
    chk("t2 wb we",     32'(txn_q[n0 + 3].we),    32'd1);
    chk("t2 wb vpn",    32'(txn_q[n0 + 3].vpn),   32'h01);
    chk("t2 wb wdata",  32'(txn_q[n0 + 3].wdata), 32'h1E);
    chk("t2 fill we",   32'(txn_q[n0 + 4].we),    32'd0);
    chk("t2 fill vpn",  32'(txn_q[n0 + 4].vpn),   32'h05);
    translate("t2 vpn1 evicted", 14'h0123, 1'b0, 1'b0, 10'h223, 6, 0);
    chk("t2 evict wb vpn", 32'(txn_q[$ - 1].vpn), 32'h02);

    // LRU honours the touch of vpn 1
    do_reset();
    translate("t4 vpn1", 14'h0100, 1'b0, 1'b0, 10'h200, 3, 0);
    translate("t4 vpn2", 14'h0200, 1'b0, 1'b0, 10'h100, 3, 0);
    translate("t4 vpn3", 14'h0300, 1'b0, 1'b0, 10'h300, 3, 0);
    translate("t4 vpn4", 14'h0400, 1'b0, 1'b0, 10'h000, 3, 0);
    translate("t4 touch1", 14'h0100, 1'b0, 1'b0, 10'h200, 1, 0);
    n0 = txn_q.size();
    translate("t4 vpn5", 14'h0500, 1'b0, 1'b0, 10'h100, 6, 0);
    chk("t4 wb we",    32'(txn_q[n0].we),        32'd1);
    chk("t4 wb vpn",   32'(txn_q[n0].vpn),       32'h02);
    chk("t4 wb wdata", 32'(txn_q[n0].wdata),     32'h15);
    chk("t4 fill vpn", 32'(txn_q[n0 + 1].vpn),   32'h05);

    // reset in the middle of a fill
    do_reset();
    translate("t5 vpn1", 14'h0123, 1'b0, 1'b0, 10'h223, 3, 0);
    pt_hold = 1'b1;
    @(negedge clock);
    cpu_req   = 1'b1;
    virt_addr = 14'h0600;
    repeat (3) @(negedge clock);
    chk("t5 pt_req in fill", 32'(pt_req), 32'd1);
    chk("t5 pt_we in fill",  32'(pt_we),  32'd0);
    chk("t5 pt_vpn in fill", 32'(pt_vpn), 32'h06);
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clock);
    chk_idle_outputs("t5 after reset");
    reset   = 1'b0;
    pt_hold = 1'b0;
    n0 = txn_q.size();
    translate("t5 vpn1 misses", 14'h0123, 1'b0, 1'b0, 10'h223, 3, 0);
    chk("t5 rewalk", 32'(txn_q.size()), 32'(n0 + 1));

    // cpu_req dropped mid-fill: walk completes silently, then hits
    pt_hold = 1'b1;
    @(negedge clock);
    cpu_req   = 1'b1;
    virt_addr = 14'h0745;
    repeat (2) @(negedge clock);
    cpu_req   = 1'b0;
    virt_addr = 14'h3FFF;
    pt_hold   = 1'b0;
    seen      = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (addr_prepared || page_fault) seen = 1'b1;
    end
    chk("t6 no pulse",  32'(seen),            32'd0);
    chk("t6 txn vpn",   32'(txn_q[$].vpn),    32'h07);
    chk("t6 txn we",    32'(txn_q[$].we),     32'd0);
    n0 = txn_q.size();
    translate("t6 hit", 14'h0745, 1'b0, 1'b0, 10'h345, 1, 0);
    chk("t6 hit no walk", 32'(txn_q.size()), 32'(n0));
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
